// File: rtl/prod_serializer.sv
//------------------------------------------------------------------------------
// prod_serializer
//
// Purpose
//   Buffers 16-bit products coming out of the upstream shift-add multiplier
//   and streams each one out as a short frame of bytes over a valid/ready
//   handshake. A small FIFO decouples the multiplier from a slow consumer.
//   A product that arrives while the FIFO is full is dropped, and a sticky
//   overflow flag records the drop.
//
//   Frame format (LSB_FIRST = 1): low byte, then high byte.
//   Frame format (LSB_FIRST = 0): high byte, then low byte.
//   With PROD_SER_CHECKSUM_EN defined, each frame gains a third byte
//   carrying (high byte ^ low byte). out_last then marks that third byte.
//
// Optional feature macro
//   PROD_SER_CHECKSUM_EN : adds the BEAT2 checksum byte to every frame.
//
// Parameters
//   FIFO_DEPTH : product buffer entries (power of two, 2..8)
//   LSB_FIRST  : 1 = low byte first, 0 = high byte first
//
// Ports
//   clk        in   1   single clock, rising-edge
//   reset      in   1   asynchronous, active-low reset
//   prod_in    in  16   unsigned product
//   prod_valid in   1   prod_in holds a finished product this cycle
//   in_ready   out  1   buffer can accept a product this cycle (!full)
//   out_byte   out  8   current serial byte
//   out_valid  out  1   out_byte is valid
//   out_ready  in   1   consumer accepts out_byte
//   out_last   out  1   current beat is the final beat of the frame
//   overflow   out  1   sticky: a product was dropped (cleared by reset only)
//   busy       out  1   FIFO non-empty or a frame is in progress
//------------------------------------------------------------------------------
module prod_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] prod_in,
    input  logic        prod_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        overflow,
    output logic        busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef PROD_SER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, BEAT2} state_t;
`else
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`endif

    state_t            state;
    logic [15:0]       frame;
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              beat_done;
    logic              final_beat;
    logic [15:0]       head;

    // Byte that opens a frame, chosen by the configured byte order.
    function automatic logic [7:0] first_byte(input logic [15:0] p);
        return LSB_FIRST ? p[7:0] : p[15:8];
    endfunction

    // Byte that follows the opening byte.
    function automatic logic [7:0] second_byte(input logic [15:0] p);
        return LSB_FIRST ? p[15:8] : p[7:0];
    endfunction

    // Wrap a pointer modulo FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status flags come straight from the registered count, so in_ready never
    // depends on out_ready: a pop this cycle does not open a slot for a push
    // in the same cycle.
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign in_ready   = !fifo_full;
    assign busy       = !fifo_empty || (state != IDLE);

    assign head       = fifo_mem[rd_ptr];
    assign push       = prod_valid && !fifo_full;
    assign beat_done  = out_valid && out_ready;

`ifdef PROD_SER_CHECKSUM_EN
    assign final_beat = (state == BEAT2);
`else
    assign final_beat = (state == BEAT1);
`endif

    // A new frame is loaded either from idle, or on the very edge the last
    // beat of the current frame is accepted, which keeps back-to-back frames
    // free of idle bubbles.
    assign pop = !fifo_empty && ((state == IDLE) || (beat_done && final_beat));

    // Storage array. It carries no reset: entries are only ever read after
    // being written, because the count guards every pop.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= prod_in;
        end
    end

    // Pointer and occupancy bookkeeping. Push and pop on the same edge leave
    // the count unchanged while both pointers advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag: any product offered while the buffer is full is lost.
    // Only reset clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (prod_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Beat sequencer. All outputs are registered here, so out_byte and
    // out_last cannot change while a beat is stalled: each state holds its
    // outputs until beat_done. When a frame is loaded, the first byte is
    // taken from the FIFO head directly because the frame register is only
    // updated on that same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            frame     <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        frame     <= head;
                        out_byte  <= first_byte(head);
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state     <= BEAT0;
                    end
                end

                BEAT0: begin
                    if (beat_done) begin
                        out_byte <= second_byte(frame);
`ifdef PROD_SER_CHECKSUM_EN
                        out_last <= 1'b0;
`else
                        out_last <= 1'b1;
`endif
                        state    <= BEAT1;
                    end
                end

`ifdef PROD_SER_CHECKSUM_EN
                BEAT1: begin
                    if (beat_done) begin
                        out_byte <= frame[15:8] ^ frame[7:0];
                        out_last <= 1'b1;
                        state    <= BEAT2;
                    end
                end

                BEAT2: begin
                    if (beat_done) begin
                        if (pop) begin
                            frame     <= head;
                            out_byte  <= first_byte(head);
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            state     <= BEAT0;
                        end else begin
                            out_byte  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
`else
                BEAT1: begin
                    if (beat_done) begin
                        if (pop) begin
                            frame     <= head;
                            out_byte  <= first_byte(head);
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            state     <= BEAT0;
                        end else begin
                            out_byte  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
`endif

                default: begin
                    out_byte  <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_serializer.sv
//------------------------------------------------------------------------------
// tb_prod_serializer
//
// Self-checking bench for prod_serializer (FIFO_DEPTH = 2, LSB_FIRST = 1).
// A queue-based reference model tracks buffered products and the bytes still
// owed for the frame on the wire; every cycle the DUT outputs are compared
// with it. A table of hand-derived vectors, several hand-written corner-case
// sequences and a randomized run drive the design.
//------------------------------------------------------------------------------
module tb_prod_serializer;

    localparam int DEPTH     = 2;
    localparam bit LSB_FIRST = 1'b1;

    logic        clk;
    logic        reset;
    logic [15:0] prod_in;
    logic        prod_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic        busy;

    int n_compared;
    int n_mismatched;

    // Reference model state.
    logic [15:0] m_fifo[$];
    logic [7:0]  m_beats[$];
    bit          m_ovf;

    // Bytes accepted by the consumer, as seen on the DUT pins.
    logic [7:0]  dut_stream[$];

    typedef struct {
        logic        pv;
        logic [15:0] pin;
        logic        ordy;
        logic        exp_valid;
        logic [7:0]  exp_byte;
        logic        exp_last;
    } vec_t;

    vec_t vecs[$];

    prod_serializer #(
        .FIFO_DEPTH (DEPTH),
        .LSB_FIRST  (LSB_FIRST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .in_ready   (in_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .busy       (busy)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bytes a product turns into on the wire.
    function automatic void load_beats(input logic [15:0] p);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = p[7:0];
        hi = p[15:8];
        m_beats.delete();
        m_beats.push_back(LSB_FIRST ? lo : hi);
        m_beats.push_back(LSB_FIRST ? hi : lo);
`ifdef PROD_SER_CHECKSUM_EN
        m_beats.push_back(lo ^ hi);
`endif
    endfunction

    // Advance the model across one rising edge given the inputs on that edge.
    function automatic void model_update(input logic pv, input logic [15:0] pin, input logic ordy);
        bit          was_idle;
        bit          fire;
        bit          final_fire;
        bit          can_push;
        logic [15:0] p;
        was_idle   = (m_beats.size() == 0);
        fire       = !was_idle && ordy;
        final_fire = fire && (m_beats.size() == 1);
        can_push   = (m_fifo.size() < DEPTH);
        if (fire) begin
            void'(m_beats.pop_front());
        end
        if ((was_idle || final_fire) && m_fifo.size() > 0) begin
            p = m_fifo.pop_front();
            load_beats(p);
        end
        if (pv) begin
            if (can_push) m_fifo.push_back(pin);
            else          m_ovf = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        m_beats.delete();
        m_ovf = 1'b0;
    endfunction

    // Compare every DUT output with the model (called away from the edge).
    task automatic check_model();
        bit         exp_valid;
        logic [7:0] exp_byte;
        exp_valid = (m_beats.size() > 0);
        exp_byte  = exp_valid ? m_beats[0] : 8'h00;
        check_output("model out_valid", 16'(out_valid), 16'(exp_valid));
        check_output("model out_last",  16'(out_last),  16'(m_beats.size() == 1));
        if (exp_valid) begin
            check_output("model out_byte", 16'(out_byte), 16'(exp_byte));
        end
        check_output("model in_ready", 16'(in_ready), 16'(m_fifo.size() < DEPTH));
        check_output("model busy",     16'(busy),     16'(m_fifo.size() > 0 || m_beats.size() > 0));
        check_output("model overflow", 16'(overflow), 16'(m_ovf));
    endtask

    // Drive inputs (caller is at a falling edge), record accepted bytes,
    // then cross the rising edge and update the model.
    task automatic apply_stimulus(input logic pv, input logic [15:0] pin, input logic ordy);
        prod_valid = pv;
        prod_in    = pin;
        out_ready  = ordy;
        if (out_valid && ordy) dut_stream.push_back(out_byte);
        @(posedge clk);
        model_update(pv, pin, ordy);
    endtask

    task automatic step(input logic pv, input logic [15:0] pin, input logic ordy);
        @(negedge clk);
        check_model();
        apply_stimulus(pv, pin, ordy);
    endtask

    // Reset with immediate check of the reset values, released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        prod_valid = 1'b0;
        prod_in    = 16'h0000;
        out_ready  = 1'b0;
        reset      = 1'b0;
        model_reset();
        #1;
        check_output("reset in_ready",  16'(in_ready),  16'h1);
        check_output("reset busy",      16'(busy),      16'h0);
        check_output("reset out_valid", 16'(out_valid), 16'h0);
        check_output("reset out_byte",  16'(out_byte),  16'h0);
        check_output("reset out_last",  16'(out_last),  16'h0);
        check_output("reset overflow",  16'(overflow),  16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dut_stream.delete();
    endtask

    task automatic check_stream(input string name, input logic [7:0] exp[$]);
        check_output({name, " length"}, 16'(dut_stream.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_stream.size(); i++) begin
            check_output(name, 16'(dut_stream[i]), 16'(exp[i]));
        end
    endtask

    function automatic vec_t mk(input logic pv, input logic [15:0] pin,
                                input logic ev, input logic [7:0] eb, input logic el);
        vec_t v;
        v.pv = pv; v.pin = pin; v.ordy = 1'b1;
        v.exp_valid = ev; v.exp_byte = eb; v.exp_last = el;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_q[$];
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        prod_valid   = 1'b0;
        prod_in      = 16'h0000;
        out_ready    = 1'b0;
        model_reset();

        // ---- Table: single product 0x1234, then back-to-back 0x00FF/0xFF00
`ifdef PROD_SER_CHECKSUM_EN
        vecs.push_back(mk(1, 16'h1234, 0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h34, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h12, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h26, 1));
        vecs.push_back(mk(1, 16'h00FF, 0, 8'h00, 0));
        vecs.push_back(mk(1, 16'hFF00, 0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'hFF, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'hFF, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'hFF, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'hFF, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0));
`else
        vecs.push_back(mk(1, 16'h1234, 0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h34, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h12, 1));
        vecs.push_back(mk(1, 16'h00FF, 0, 8'h00, 0));
        vecs.push_back(mk(1, 16'hFF00, 0, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'hFF, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h00, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 8'h00, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 8'hFF, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0));
`endif
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_output("table out_valid", 16'(out_valid), 16'(vecs[i].exp_valid));
            check_output("table out_last",  16'(out_last),  16'(vecs[i].exp_last));
            if (vecs[i].exp_valid) begin
                check_output("table out_byte", 16'(out_byte), 16'(vecs[i].exp_byte));
            end
            check_model();
            apply_stimulus(vecs[i].pv, vecs[i].pin, vecs[i].ordy);
        end

        // ---- Backpressure: 0xABCD held for 5 stalled cycles
        do_reset();
        step(1, 16'hABCD, 0);
        step(0, 16'h0000, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 16'h0000, 0);
            #1;
            check_output("stall out_valid", 16'(out_valid), 16'h1);
            check_output("stall out_byte",  16'(out_byte),  16'h00CD);
            check_output("stall out_last",  16'(out_last),  16'h0);
        end
        repeat (4) step(0, 16'h0000, 1);
`ifdef PROD_SER_CHECKSUM_EN
        exp_q = '{8'hCD, 8'hAB, 8'h66};
`else
        exp_q = '{8'hCD, 8'hAB};
`endif
        check_stream("stall stream", exp_q);

        // ---- Overflow: 1, 2, 3 accepted (first pop frees a slot), 4 dropped
        do_reset();
        step(1, 16'h0001, 0);
        step(1, 16'h0002, 0);
        step(1, 16'h0003, 0);
        #1;
        check_output("ovf in_ready full", 16'(in_ready), 16'h0);
        check_output("ovf not yet",       16'(overflow), 16'h0);
        step(1, 16'h0004, 0);
        #1;
        check_output("ovf sticky set", 16'(overflow), 16'h1);
        repeat (12) step(0, 16'h0000, 1);
        #1;
        check_output("ovf still set", 16'(overflow), 16'h1);
        check_output("ovf drained busy", 16'(busy), 16'h0);
`ifdef PROD_SER_CHECKSUM_EN
        exp_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h00, 8'h02, 8'h03, 8'h00, 8'h03};
`else
        exp_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
`endif
        check_stream("ovf stream", exp_q);

        // ---- Reset mid-frame: after 0x34 is accepted, 0x12 must never appear
        do_reset();
        step(1, 16'h1234, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst out_valid", 16'(out_valid), 16'h0);
        check_output("midrst out_byte",  16'(out_byte),  16'h0);
        check_output("midrst out_last",  16'(out_last),  16'h0);
        check_output("midrst busy",      16'(busy),      16'h0);
        check_output("midrst in_ready",  16'(in_ready),  16'h1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        dut_stream.delete();
        repeat (4) step(0, 16'h0000, 1);
        #1;
        check_output("midrst busy after", 16'(busy), 16'h0);
        check_output("midrst no beats",   16'(dut_stream.size()), 16'h0);

        // ---- Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 65);
        end
        repeat (10) step(0, 16'h0000, 1);
        @(negedge clk);
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/prod_serializer.md
PROD_SERIALIZER -- requirements
Module: prod_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning product buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning 1 = low byte sent first, 0 = high byte first.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port prod_in  input  16  unsigned product from the upstream shift-add multiplier.
REQ-006 SHALL have port prod_valid  input  1  prod_in holds a finished product this cycle.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a product this cycle.
REQ-008 SHALL have port out_byte  output  8  current serial byte.
REQ-009 SHALL have port out_valid  output  1  out_byte is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_byte.
REQ-011 SHALL have port out_last  output  1  current beat is the final beat of a product frame.
REQ-012 SHALL have port overflow  output  1  sticky flag: a product was dropped.
REQ-013 SHALL have port busy  output  1  buffer non-empty or frame in progress.

Function
REQ-014 SHALL push prod_in into the FIFO on an edge where prod_valid && in_ready.
REQ-015 SHALL drive in_ready = !full, independent of out_ready; a pop in the same cycle SHALL NOT free a slot for a push that cycle.
REQ-016 SHALL drop prod_in and set overflow on an edge where prod_valid && !in_ready; overflow SHALL clear only on reset.
REQ-017 SHALL implement FSM states IDLE, BEAT0, BEAT1 (plus BEAT2 per REQ-029).
REQ-018 IDLE -> BEAT0 SHALL occur on the first edge with FIFO non-empty; that edge pops the head into a 16-bit frame register.
REQ-019 A product pushed at edge N into an empty idle block SHALL appear as out_valid=1 after edge N+1 (one-cycle latency).
REQ-020 BEAT0 SHALL present the low byte when LSB_FIRST=1, else the high byte; BEAT1 SHALL present the other byte.
REQ-021 A beat SHALL complete on an edge with out_valid && out_ready; the FSM SHALL advance only then.
REQ-022 out_byte and out_last SHALL remain stable while out_valid && !out_ready.
REQ-023 out_last SHALL be 1 only in the final beat state of a frame.
REQ-024 On completion of the final beat, the FSM SHALL pop the next product and enter BEAT0 on the same edge if the FIFO is non-empty (no idle bubble), else enter IDLE.
REQ-025 out_valid SHALL be 1 in every BEAT state and 0 in IDLE.
REQ-026 busy SHALL be 1 when the FIFO is non-empty or the state is not IDLE.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range from 0 to FIFO_DEPTH inclusive.

Reset
REQ-028 On reset low, the block SHALL immediately set state=IDLE, FIFO empty, frame register=0, out_byte=0, out_valid=0, out_last=0, overflow=0, busy=0, and in_ready=1; a frame in progress SHALL be discarded with no partial beats after release.

Configuration
REQ-029 With macro PROD_SER_CHECKSUM_EN defined, each frame SHALL add a third beat BEAT2 carrying the XOR of the high and low bytes, out_last SHALL move to BEAT2, and BEAT1 SHALL advance to BEAT2; without the macro, BEAT1 is final and BEAT2 SHALL NOT exist.

Verification
REQ-030 Single product: push 0x1234 with out_ready=1 -> beats 0x34, 0x12, with out_last on 0x12; first out_valid one cycle after the push.
REQ-031 Backpressure: push 0xABCD and hold out_ready=0 for 5 cycles -> out_byte stays 0xCD with out_valid=1; releasing gives 0xCD then 0xAB.
REQ-032 Overflow: out_ready=0 and push 0x0001, 0x0002, 0x0003 (FIFO_DEPTH=2) -> the first pop frees one slot, so 0x0003 is accepted only if in_ready=1 at its push; otherwise overflow=1 and the output stream is 01 00 02 00 only.
REQ-033 Back-to-back: push 0x00FF and 0xFF00, out_ready=1 -> FF 00 00 FF, out_valid continuous, no gap cycle.
REQ-034 Reset mid-frame: assert reset after beat 0x34 of 0x1234 -> all outputs reset at once; after release, no 0x12 beat and busy=0.
REQ-035 With PROD_SER_CHECKSUM_EN, push 0x1234 -> 0x34, 0x12, 0x26, with out_last on 0x26.
